log_bram_reader: RTL and testbench

- Drains a timestamped AXI access log from its BRAM after capture, as the readout stage downstream of the AXI BRAM logger.
- Issues sequential 32-bit word reads to the BRAM read port and absorbs the fixed BRAM read latency.
- Presents the words in order on a valid/ready stream towards the host-side readout (e.g. a DMA or AXI-Lite FIFO).
- Full throughput of one word per cycle under no backpressure; lossless under arbitrary backpressure.

---
 rtl/log_bram_reader_if.sv | 33 +++
 rtl/log_bram_reader.sv | 161 ++++++++++++++++
 tb/tb_log_bram_reader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/log_bram_reader_if.sv
// Control, BRAM read port and output stream of the log BRAM reader.
// master: the reader; slave: the BRAM/host environment.
interface log_bram_reader_if #(
    parameter int AW = 16,
    parameter int CW = 15
);
    logic          Start_SI;
    logic          Abort_SI;
    logic [CW-1:0] NumEntries_DI;
    logic          Busy_SO;
    logic          Done_SO;
    logic          BramEn_SO;
    logic [AW-1:0] BramAddr_SO;
    logic [31:0]   BramRdData_DI;
    logic          OutValid_SO;
    logic          OutReady_SI;
    logic [31:0]   OutData_DO;
    logic          OutLast_SO;

    modport master (
        input  Start_SI, Abort_SI, NumEntries_DI,
        input  BramRdData_DI, OutReady_SI,
        output Busy_SO, Done_SO, BramEn_SO, BramAddr_SO,
        output OutValid_SO, OutData_DO, OutLast_SO
    );

    modport slave (
        output Start_SI, Abort_SI, NumEntries_DI,
        output BramRdData_DI, OutReady_SI,
        input  Busy_SO, Done_SO, BramEn_SO, BramAddr_SO,
        input  OutValid_SO, OutData_DO, OutLast_SO
    );
endinterface

// File: rtl/log_bram_reader.sv
// Drains the AXI access log BRAM word by word onto a valid/ready stream.
// Reads are credit-limited so the output buffer can never overflow.
module log_bram_reader #(
    parameter int NUM_LOG_ENTRIES = 16384,
    parameter int WORDS_PER_ENTRY = 3,
    parameter int BRAM_LATENCY    = 2
) (
    input  logic               Clk_CI,
    input  logic               Rst_RI,
    log_bram_reader_if.master  bus
);
    localparam int FIFO_DEPTH = BRAM_LATENCY + 2;
    localparam int AW = $clog2(NUM_LOG_ENTRIES * WORDS_PER_ENTRY);
    localparam int CW = $clog2(NUM_LOG_ENTRIES + 1);
    localparam int NW = AW + 1;
    localparam int MD = FIFO_DEPTH - 1;
    localparam int PW = $clog2(MD);
    localparam int KW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, FLUSH} state_t;

    state_t state_q, state_d;

    logic [AW-1:0]           addr_q, last_q, dcnt_q;
    logic [BRAM_LATENCY-1:0] sr_q;
    logic [31:0]             mem_q [MD];
    logic [PW-1:0]           wr_q, rd_q;
    logic [KW-1:0]           cnt_q, flush_q, infl;
    logic                    ov_q, done_q;
    logic [31:0]             od_q;

    logic [CW-1:0] clamp;
    logic [NW-1:0] ntot;
    logic          start_ok, abort, credit, bram_en;
    logic          push, pop, take, mem_rd, mem_wr, is_last;

    always_comb begin
        clamp = (bus.NumEntries_DI > CW'(NUM_LOG_ENTRIES))
              ? CW'(NUM_LOG_ENTRIES) : bus.NumEntries_DI;
        ntot  = NW'(clamp) * NW'(WORDS_PER_ENTRY);
    end

    always_comb begin
        infl = '0;
        for (int i = 0; i < BRAM_LATENCY; i++)
            infl = infl + KW'(sr_q[i]);
    end

    assign start_ok = (state_q == IDLE) && bus.Start_SI && !bus.Abort_SI;
    assign abort    = bus.Abort_SI && (state_q == READ || state_q == DRAIN);
    assign credit   = (cnt_q + KW'(ov_q) + infl) < KW'(FIFO_DEPTH);
    assign is_last  = (dcnt_q == last_q);

    assign push   = sr_q[BRAM_LATENCY-1]
                  && (state_q == READ || state_q == DRAIN);
    assign pop    = ov_q && bus.OutReady_SI;
    assign take   = !ov_q || pop;
    assign mem_rd = take && (cnt_q != '0);
    // Returning data bypasses the buffer when it is empty and the
    // output register is free, giving the one-cycle write-to-valid path.
    assign mem_wr = push && !(take && (cnt_q == '0));

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        bram_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok && ntot != '0) state_d = READ;
            end
            READ: begin
                if (abort) begin
                    state_d = FLUSH;
                end else begin
                    bram_en = credit && !Rst_RI;
                    if (credit && addr_q == last_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort)               state_d = FLUSH;
                else if (pop && is_last) state_d = IDLE;
            end
            FLUSH: begin
                if (flush_q == KW'(BRAM_LATENCY - 1)) state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (mem_wr) mem_q[wr_q] <= bus.BramRdData_DI;
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            addr_q  <= '0;
            last_q  <= '0;
            dcnt_q  <= '0;
            sr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            flush_q <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            sr_q[0] <= bram_en;
            for (int i = 1; i < BRAM_LATENCY; i++)
                sr_q[i] <= sr_q[i-1];

            if (start_ok) begin
                addr_q <= '0;
                dcnt_q <= '0;
                last_q <= AW'(ntot - NW'(1));
            end else begin
                if (bram_en && addr_q != last_q) addr_q <= addr_q + 1'b1;
                if (pop) dcnt_q <= dcnt_q + 1'b1;
            end

            flush_q <= (state_q == FLUSH) ? flush_q + 1'b1 : '0;

            done_q <= (start_ok && ntot == '0)
                   || (state_q == DRAIN && !abort && pop && is_last);

            if (abort) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
                ov_q  <= 1'b0;
            end else begin
                if (take) begin
                    if (mem_rd) begin
                        ov_q <= 1'b1;
                        od_q <= mem_q[rd_q];
                        rd_q <= (rd_q == PW'(MD - 1)) ? '0 : rd_q + 1'b1;
                    end else if (push) begin
                        ov_q <= 1'b1;
                        od_q <= bus.BramRdData_DI;
                    end else begin
                        ov_q <= 1'b0;
                    end
                end
                if (mem_wr)
                    wr_q <= (wr_q == PW'(MD - 1)) ? '0 : wr_q + 1'b1;
                cnt_q <= cnt_q + KW'(mem_wr) - KW'(mem_rd);
            end
        end
    end

    assign bus.Busy_SO     = (state_q != IDLE);
    assign bus.Done_SO     = done_q;
    assign bus.BramEn_SO   = bram_en;
    assign bus.BramAddr_SO = addr_q;
    assign bus.OutValid_SO = ov_q;
    assign bus.OutData_DO  = od_q;
    assign bus.OutLast_SO  = ov_q && is_last;
endmodule

// File: tb/tb_log_bram_reader.sv
// Directed bench for log_bram_reader with a latency-2 BRAM model.
// Covers timing, backpressure, empty log, clamp, abort and reset.
module tb_log_bram_reader;
    localparam int NUM = 16384;
    localparam int WPE = 3;
    localparam int LAT = 2;
    localparam int AW  = $clog2(NUM * WPE);
    localparam int CW  = $clog2(NUM + 1);

    typedef struct {
        int num;
        int stall;
        int words;
        int max_rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [31:0] p1 = '0, p2 = '0;

    log_bram_reader_if #(.AW(AW), .CW(CW)) bus ();

    log_bram_reader #(
        .NUM_LOG_ENTRIES(NUM),
        .WORDS_PER_ENTRY(WPE),
        .BRAM_LATENCY(LAT)
    ) dut (
        .Clk_CI(clk),
        .Rst_RI(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f(input int a);
        logic [15:0] x;
        x = a[15:0];
        return {16'hA5C3 ^ x, x};
    endfunction

    always @(posedge clk) begin
        p1 <= bus.BramEn_SO ? f(int'(bus.BramAddr_SO)) : 32'h0;
        p2 <= p1;
    end
    assign bus.BramRdData_DI = p2;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  bus.Busy_SO, 0);
        chk({tag, "_done"},  bus.Done_SO, 0);
        chk({tag, "_en"},    bus.BramEn_SO, 0);
        chk({tag, "_addr"},  bus.BramAddr_SO, 0);
        chk({tag, "_valid"}, bus.OutValid_SO, 0);
        chk({tag, "_data"},  bus.OutData_DO, 0);
        chk({tag, "_last"},  bus.OutLast_SO, 0);
    endtask

    task automatic run_dump(input vec_t v);
        int words, reads, last_hs, budget;
        bit got_done, seen_v, prev_v;
        logic [31:0] prev_d;
        words = 0; reads = 0; last_hs = 0;
        got_done = 0; seen_v = 0; prev_v = 0; prev_d = '0;
        budget = v.words * 2 + v.stall + 50;
        @(negedge clk);
        bus.Start_SI      = 1'b1;
        bus.NumEntries_DI = CW'(v.num);
        bus.OutReady_SI   = 1'b0;
        for (int c = 1; c <= budget && !got_done; c++) begin
            @(negedge clk);
            bus.Start_SI    = 1'b0;
            bus.OutReady_SI = (c > v.stall);
            if (v.stall > 0 && c == v.stall + 1)
                chk("stall_reads_le", reads <= v.max_rd, 1);
            if (bus.BramEn_SO) begin
                chk("rd_addr", bus.BramAddr_SO, reads);
                reads++;
            end
            if (c <= v.stall && prev_v) begin
                chk("stall_valid", bus.OutValid_SO, 1);
                chk("stall_data", bus.OutData_DO, prev_d);
            end
            if (c > v.stall && seen_v && words < v.words)
                chk("no_gap", bus.OutValid_SO, 1);
            if (bus.OutValid_SO) seen_v = 1;
            prev_v = bus.OutValid_SO;
            prev_d = bus.OutData_DO;
            if (bus.OutValid_SO && bus.OutReady_SI) begin
                chk("data", bus.OutData_DO, f(words));
                chk("last", bus.OutLast_SO, words == v.words - 1);
                words++;
                last_hs = c;
            end
            if (bus.Done_SO) begin
                got_done = 1;
                chk("done_cycle", c, last_hs + 1);
                chk("busy_at_done", bus.Busy_SO, 0);
            end
        end
        chk("words", words, v.words);
        chk("reads", reads, v.words);
        chk("done_seen", got_done, 1);
        @(negedge clk);
        chk("done_pulse_end", bus.Done_SO, 0);
    endtask

    task automatic seq_basic();
        @(negedge clk);
        bus.Start_SI      = 1'b1;
        bus.NumEntries_DI = CW'(2);
        bus.OutReady_SI   = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            bus.Start_SI = 1'b0;
            chk("b_en", bus.BramEn_SO, c <= 6);
            if (c <= 6) chk("b_addr", bus.BramAddr_SO, c - 1);
            chk("b_valid", bus.OutValid_SO, c >= 4 && c <= 9);
            if (bus.OutValid_SO) chk("b_data", bus.OutData_DO, f(c - 4));
            chk("b_last", bus.OutLast_SO, c == 9);
            chk("b_done", bus.Done_SO, c == 10);
            chk("b_busy", bus.Busy_SO, c <= 9);
        end
    endtask

    task automatic seq_abort();
        int hs;
        vec_t v;
        hs = 0;
        @(negedge clk);
        bus.Start_SI      = 1'b1;
        bus.NumEntries_DI = CW'(4);
        bus.OutReady_SI   = 1'b1;
        for (int c = 0; c < 40 && hs < 5; c++) begin
            @(negedge clk);
            bus.Start_SI = 1'b0;
            if (bus.OutValid_SO && bus.OutReady_SI) hs++;
        end
        chk("a_hs", hs, 5);
        @(negedge clk);
        chk("a_pre_valid", bus.OutValid_SO, 1);
        bus.OutReady_SI = 1'b0;
        bus.Abort_SI    = 1'b1;
        @(negedge clk);
        bus.Abort_SI      = 1'b0;
        bus.Start_SI      = 1'b1;
        bus.NumEntries_DI = CW'(1);
        chk("a1_valid", bus.OutValid_SO, 0);
        chk("a1_en", bus.BramEn_SO, 0);
        chk("a1_busy", bus.Busy_SO, 1);
        chk("a1_done", bus.Done_SO, 0);
        @(negedge clk);
        bus.Start_SI = 1'b0;
        chk("a2_busy", bus.Busy_SO, 1);
        chk("a2_en", bus.BramEn_SO, 0);
        chk("a2_done", bus.Done_SO, 0);
        @(negedge clk);
        chk("a3_busy", bus.Busy_SO, 0);
        chk("a3_done", bus.Done_SO, 0);
        @(negedge clk);
        chk("a4_busy", bus.Busy_SO, 0);
        chk("a4_en", bus.BramEn_SO, 0);
        chk("a4_valid", bus.OutValid_SO, 0);
        v = '{num: 2, stall: 0, words: 6, max_rd: 4};
        run_dump(v);
    endtask

    task automatic seq_reset();
        vec_t v;
        @(negedge clk);
        bus.Start_SI      = 1'b1;
        bus.NumEntries_DI = CW'(4);
        bus.OutReady_SI   = 1'b1;
        @(negedge clk);
        bus.Start_SI = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("r_pre_busy", bus.Busy_SO, 1);
        rst = 1'b1;
        @(negedge clk);
        chk_zero("r1");
        @(negedge clk);
        chk_zero("r2");
        rst = 1'b0;
        v = '{num: 1, stall: 0, words: 3, max_rd: 4};
        run_dump(v);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: time limit expired");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{num: 2,     stall: 0,  words: 6,     max_rd: 4};
        vecs[1] = '{num: 4,     stall: 10, words: 12,    max_rd: 4};
        vecs[2] = '{num: 0,     stall: 0,  words: 0,     max_rd: 4};
        vecs[3] = '{num: 1,     stall: 3,  words: 3,     max_rd: 4};
        vecs[4] = '{num: 5,     stall: 0,  words: 15,    max_rd: 4};
        vecs[5] = '{num: 20000, stall: 0,  words: 49152, max_rd: 4};

        bus.Start_SI      = 1'b0;
        bus.Abort_SI      = 1'b0;
        bus.NumEntries_DI = '0;
        bus.OutReady_SI   = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_zero("rst");
        rst = 1'b0;

        seq_basic();
        for (int i = 0; i < 6; i++) run_dump(vecs[i]);

        @(negedge clk);
        bus.Start_SI      = 1'b1;
        bus.Abort_SI      = 1'b1;
        bus.NumEntries_DI = CW'(3);
        @(negedge clk);
        bus.Start_SI = 1'b0;
        bus.Abort_SI = 1'b0;
        chk("both_busy", bus.Busy_SO, 0);
        chk("both_done", bus.Done_SO, 0);
        chk("both_en", bus.BramEn_SO, 0);

        seq_abort();
        seq_reset();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
